// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit microcode processor.
// Owns the program counter and instruction register, and handles J/JNZ and memory-operand stalls.
module instr_sequencer #(
  parameter logic [3:0] LAST_ADDR   = 4'd15,
  parameter logic [3:0] MEM_TIMEOUT = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       z_flag,
  input  logic       mem_ack,
  output logic [3:0] pc,
  output logic [7:0] ir,
  output logic       fetch_en,
  output logic       exec_en,
  output logic       mem_req,
  output logic       busy,
  output logic       halted,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] TMO_LAST = MEM_TIMEOUT - 4'd1;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       err_q, err_d;
  logic [3:0] tmo_q, tmo_d;

  logic [3:0] target;
  logic       is_j, is_jnz, is_mem, jump_taken, at_last;

  assign target     = ir_q[3:0];
  assign is_j       = (ir_q[7:4] == 4'h7);
  assign is_jnz     = (ir_q[7:4] == 4'h3);
  assign is_mem     = (ir_q[7:4] == 4'hB) || (ir_q[7:4] == 4'hF);
  assign jump_taken = is_j || (is_jnz && !z_flag);
  assign at_last    = (pc_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 4'd0;
      ir_q    <= 8'h00;
      err_q   <= 1'b0;
      tmo_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    fetch_en = 1'b0;
    exec_en  = 1'b0;
    mem_req  = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 4'd0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        busy     = 1'b1;
        ir_d     = instr;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        busy    = 1'b1;
        tmo_d   = 4'd0;
        state_d = is_mem ? S_MEM_WAIT : S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        exec_en = 1'b1;
        // A taken jump from the last address keeps running; only fall-through halts.
        if (!jump_taken && at_last) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = jump_taken ? target : pc_q + 4'd1;
        end
      end
      S_MEM_WAIT: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          exec_en = 1'b1;
          if (at_last) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            pc_d    = pc_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 4'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc  = pc_q;
  assign ir  = ir_q;
  assign err = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed programs plus random programs
// checked cycle by cycle against an instruction-level reference model.
module tb_instr_sequencer;
  localparam logic [3:0] LAST = 4'd2;
  localparam int         TMO  = 8;

  logic       clk = 1'b0;
  logic       rst, start, z_flag, mem_ack;
  logic [7:0] instr;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       fetch_en, exec_en, mem_req, busy, halted, err;

  logic [7:0] prog    [16];
  logic       z_tab   [16];
  int         ack_tab [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instr = prog[pc];

  instr_sequencer #(.LAST_ADDR(LAST), .MEM_TIMEOUT(4'(TMO))) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .z_flag(z_flag),
    .mem_ack(mem_ack), .pc(pc), .ir(ir), .fetch_en(fetch_en), .exec_en(exec_en),
    .mem_req(mem_req), .busy(busy), .halted(halted), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_strobes"}, {fetch_en, exec_en, mem_req}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Runs one instruction starting in its FETCH cycle; returns the model's next pc/halt/err.
  task automatic exec_one(input logic [3:0] exp_pc, input int ack_at, input logic zv,
                          output logic halt_o, output logic err_o, output logic [3:0] next_pc);
    logic [7:0] ins;
    logic [3:0] op;
    logic       memc, jump, acked;
    int         k;
    ins  = prog[exp_pc];
    op   = ins[7:4];
    memc = (op == 4'hB) || (op == 4'hF);
    jump = (op == 4'h7) || ((op == 4'h3) && !zv);
    acked = 1'b0;

    z_flag = 1'($urandom); mem_ack = 1'($urandom);
    @(negedge clk);
    chk("fetch_pc", pc, exp_pc);
    chk("fetch_en", fetch_en, 1);
    chk("fetch_exec_mem", {exec_en, mem_req}, 0);
    chk("fetch_busy", busy, 1);
    chk("fetch_err", err, 0);
    tick();

    start = ($urandom_range(0, 3) == 0);
    z_flag = 1'($urandom); mem_ack = 1'($urandom);
    @(negedge clk);
    chk("dec_ir", ir, ins);
    chk("dec_strobes", {fetch_en, exec_en, mem_req}, 0);
    chk("dec_busy", busy, 1);
    tick();
    start = 1'b0;

    if (memc) begin
      k = 0;
      while (!acked && k < TMO) begin
        k++;
        mem_ack = (k == ack_at);
        z_flag  = 1'($urandom);
        @(negedge clk);
        chk("mw_req", mem_req, 1);
        chk("mw_exec", exec_en, (k == ack_at));
        chk("mw_fetch", fetch_en, 0);
        chk("mw_pc", pc, exp_pc);
        acked = (k == ack_at);
        tick();
      end
      mem_ack = 1'b0;
    end else begin
      z_flag = zv; mem_ack = 1'($urandom);
      @(negedge clk);
      chk("ex_exec", exec_en, 1);
      chk("ex_fetch_req", {fetch_en, mem_req}, 0);
      tick();
    end

    err_o = 1'b0;
    if (memc && !acked) begin
      halt_o = 1'b1; err_o = 1'b1; next_pc = exp_pc;
    end else if (!(jump && !memc) && exp_pc == LAST) begin
      halt_o = 1'b1; next_pc = exp_pc;
    end else begin
      halt_o  = 1'b0;
      next_pc = (jump && !memc) ? ins[3:0] : 4'((exp_pc + 1) % 16);
    end
  endtask

  // Starts from IDLE/HALT and runs until halt or max_instr instructions (then resets mid-run).
  task automatic run_prog(input bit use_tab, input int max_instr);
    logic [3:0] p;
    logic       h, e, zv;
    int         cnt, ack_at;
    p = 4'd0; h = 1'b0; e = 1'b0; cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!h && cnt < max_instr) begin
      if (use_tab) begin
        zv = z_tab[p]; ack_at = ack_tab[p];
      end else begin
        zv = 1'($urandom_range(0, 1));
        ack_at = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO);
      end
      exec_one(p, ack_at, zv, h, e, p);
      cnt++;
    end
    if (h) begin
      z_flag = 1'($urandom); mem_ack = 1'($urandom);
      @(negedge clk);
      $display("program done: halted pc=%0h err=%0b after %0d instr", pc, err, cnt);
      chk("halt_flag", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_pc", pc, p);
      chk("halt_err", err, e);
      chk("halt_strobes", {fetch_en, exec_en, mem_req}, 0);
      tick();
    end else begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      $display("program cut at %0d instr by reset", cnt);
      check_reset("mid_rst");
      tick();
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i] = 8'h00; z_tab[i] = 1'b0; ack_tab[i] = 1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; z_flag = 1'b0; mem_ack = 1'b0;
    clear_prog();
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("por");
    tick();

    // Plain program halting at LAST_ADDR.
    prog[0] = 8'h23; prog[1] = 8'h48; prog[2] = 8'h0C;
    run_prog(1'b1, 10);

    // J 6, JNZ taken/not taken, memory ack on 3rd wait cycle, J back to LAST_ADDR.
    clear_prog();
    prog[0] = 8'h23; prog[1] = 8'h76;
    prog[6] = 8'h38; z_tab[6] = 1'b0;
    prog[8] = 8'h38; z_tab[8] = 1'b1;
    prog[9] = 8'hBA; ack_tab[9] = 3;
    prog[10] = 8'h72;
    prog[2] = 8'h72;
    prog[3] = 8'h0C;
    run_prog(1'b1, 12);

    // Memory timeout halts with err; following start clears it.
    clear_prog();
    prog[0] = 8'hF5; ack_tab[0] = 0;
    run_prog(1'b1, 4);
    prog[0] = 8'h11;
    run_prog(1'b1, 6);

    // Start while busy is ignored; reset during MEM_WAIT returns to IDLE.
    clear_prog();
    prog[0] = 8'hBA;
    mem_ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1;
    @(negedge clk);
    chk("mw1_req", mem_req, 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_req", mem_req, 1);
    chk("busy_start_pc", pc, 0);
    chk("busy_start_fetch", fetch_en, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    $display("reset during MEM_WAIT applied");
    check_reset("mw_rst");
    tick();
    @(negedge clk);
    chk("idle_stays", {busy, halted}, 0);
    tick();

    // Random programs.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] rn;
        rn = 4'($urandom);
        case ($urandom_range(0, 5))
          0: prog[i] = {4'h7, rn};
          1: prog[i] = {4'h3, rn};
          2: prog[i] = {($urandom_range(0, 1) == 1) ? 4'hB : 4'hF, rn};
          default: prog[i] = 8'($urandom);
        endcase
      end
      run_prog(1'b0, 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
